// File: rtl/neopixel_frame_tx_if.sv
// Load/send handshake between the pattern generator and the strip driver.
// The generator is the master: it addresses the frame buffer and fires sends,
// and it watches the two ready flags to know when either is honoured.
interface neopixel_frame_tx_if;
  logic [2:0] pixel_index;
  logic [1:0] color_index;
  logic [7:0] color_level;
  logic       load_color;
  logic       send_it;
  logic       ready_to_load;
  logic       ready_to_send;

  modport master (
    output pixel_index,
    output color_index,
    output color_level,
    output load_color,
    output send_it,
    input  ready_to_load,
    input  ready_to_send
  );

  modport slave (
    input  pixel_index,
    input  color_index,
    input  color_level,
    input  load_color,
    input  send_it,
    output ready_to_load,
    output ready_to_send
  );
endinterface

// File: rtl/neopixel_frame_tx.sv
// WS2812 strip driver: holds a NUM_PIXELS x RGB frame buffer written over the
// load handshake and, on a send, shifts it out on neo_data as GRB MSB-first
// bits followed by the low latch gap that makes the strip display the frame.
module neopixel_frame_tx #(
  parameter int NUM_PIXELS = 5,
  parameter int T_BIT      = 63,
  parameter int T0H        = 18,
  parameter int T1H        = 35,
  parameter int T_LATCH    = 2500
) (
  input  logic                clock,
  input  logic                reset,
  neopixel_frame_tx_if.slave  bus,
  output logic                neo_data
);

  localparam int CW = $clog2(T_LATCH + 1);

  localparam logic [CW-1:0] T0H_LEN    = CW'(T0H);
  localparam logic [CW-1:0] T1H_LEN    = CW'(T1H);
  localparam logic [CW-1:0] BIT_END    = CW'(T_BIT - 1);
  localparam logic [CW-1:0] TAIL_END   = CW'(T_BIT);
  localparam logic [CW-1:0] LATCH_END  = CW'(T_LATCH - 1);

  typedef enum logic [1:0] {
    IDLE,
    BIT_HIGH,
    BIT_LOW,
    LATCH
  } state_t;

  state_t        state;
  logic [CW-1:0] cycle_cnt;
  logic [4:0]    bit_cnt;
  logic [2:0]    pix_cnt;

  logic [7:0]    frame_buf [NUM_PIXELS][3];

  logic          write_en;
  logic [7:0]    cur_byte;
  logic          cur_bit;
  logic [CW-1:0] high_len;
  logic          last_bit;

  // A write lands only in IDLE and only at a real pixel / colour slot.
  assign write_en = bus.load_color && bus.ready_to_load &&
                    (int'(bus.pixel_index) < NUM_PIXELS) &&
                    (bus.color_index != 2'd3);

  assign last_bit = (bit_cnt == 5'd23) && (int'(pix_cnt) == NUM_PIXELS - 1);

  // Frame buffer: cleared by reset, otherwise only changed by accepted writes,
  // so it stays frozen while a frame is on the wire and persists between frames.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int p = 0; p < NUM_PIXELS; p++) begin
        for (int c = 0; c < 3; c++) begin
          frame_buf[p][c] <= 8'h00;
        end
      end
    end else if (write_en) begin
      frame_buf[bus.pixel_index][bus.color_index] <= bus.color_level;
    end
  end

  // Pick the bit on the wire: green, red, blue bytes in turn, MSB first.
  always_comb begin
    cur_byte = 8'h00;
    case (bit_cnt[4:3])
      2'd0:    cur_byte = frame_buf[pix_cnt][1];
      2'd1:    cur_byte = frame_buf[pix_cnt][0];
      2'd2:    cur_byte = frame_buf[pix_cnt][2];
      default: cur_byte = 8'h00;
    endcase
    cur_bit  = cur_byte[~bit_cnt[2:0]];
    high_len = cur_bit ? T1H_LEN : T0H_LEN;
  end

  // Transmit sequencer. neo_data is registered one edge behind the state, so
  // each bit's slot runs from the edge after entering BIT_HIGH; the buffer is
  // read from that edge on, which lets a write made with the send be sent.
  // The last bit stays one count longer in BIT_LOW so that the full latch gap
  // is measured from the final low clock actually driven on the wire.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= LATCH;
      cycle_cnt     <= '0;
      bit_cnt       <= '0;
      pix_cnt       <= '0;
      neo_data      <= 1'b0;
      bus.ready_to_load <= 1'b0;
      bus.ready_to_send <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          neo_data <= 1'b0;
          if (bus.send_it) begin
            state             <= BIT_HIGH;
            cycle_cnt         <= '0;
            bit_cnt           <= '0;
            pix_cnt           <= '0;
            bus.ready_to_load <= 1'b0;
            bus.ready_to_send <= 1'b0;
          end
        end

        BIT_HIGH: begin
          cycle_cnt <= cycle_cnt + 1'b1;
          if (cycle_cnt == high_len) begin
            neo_data <= 1'b0;
            state    <= BIT_LOW;
          end else begin
            neo_data <= 1'b1;
          end
        end

        BIT_LOW: begin
          neo_data <= 1'b0;
          if (!last_bit && (cycle_cnt == BIT_END)) begin
            cycle_cnt <= '0;
            state     <= BIT_HIGH;
            if (bit_cnt == 5'd23) begin
              bit_cnt <= '0;
              pix_cnt <= pix_cnt + 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (last_bit && (cycle_cnt == TAIL_END)) begin
            cycle_cnt <= '0;
            bit_cnt   <= '0;
            pix_cnt   <= '0;
            state     <= LATCH;
          end else begin
            cycle_cnt <= cycle_cnt + 1'b1;
          end
        end

        LATCH: begin
          neo_data <= 1'b0;
          if (cycle_cnt == LATCH_END) begin
            cycle_cnt         <= '0;
            state             <= IDLE;
            bus.ready_to_load <= 1'b1;
            bus.ready_to_send <= 1'b1;
          end else begin
            cycle_cnt <= cycle_cnt + 1'b1;
          end
        end

        default: begin
          neo_data          <= 1'b0;
          cycle_cnt         <= '0;
          state             <= LATCH;
          bus.ready_to_load <= 1'b0;
          bus.ready_to_send <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neopixel_frame_tx.sv
// Bench for neopixel_frame_tx: drives loads and sends through the interface,
// records neo_data every clock and decodes it into bits, comparing against a
// frame-buffer model that expands each pixel into GRB MSB-first bits.
module tb_neopixel_frame_tx;

  localparam int NP        = 5;
  localparam int TBIT      = 63;
  localparam int T0        = 18;
  localparam int T1        = 35;
  localparam int TL        = 2500;
  localparam int NBITS     = NP * 24;
  localparam int BITS_END  = NBITS * TBIT;
  localparam int FRAME_LEN = BITS_END + TL + 1;

  logic clock;
  logic reset;
  logic neo_data;

  neopixel_frame_tx_if bus ();

  neopixel_frame_tx dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus),
    .neo_data (neo_data)
  );

  int vectors;
  int miscompares;

  logic [7:0] model_buf [NP][3];
  bit         neo_tr [0:FRAME_LEN];
  bit         rl_tr  [0:FRAME_LEN];
  bit         rs_tr  [0:FRAME_LEN];
  bit         meas_bits [NBITS];
  bit         prev_bits [NBITS];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: buffer updates and the bit expected at frame position i.
  task automatic model_write(input int pix, input int col, input logic [7:0] lvl);
    if (pix < NP && col != 3) model_buf[pix][col] = lvl;
  endtask

  task automatic model_clear();
    for (int p = 0; p < NP; p++)
      for (int c = 0; c < 3; c++) model_buf[p][c] = 8'h00;
  endtask

  function automatic bit exp_bit(input int i);
    int p = i / 24;
    int b = i % 24;
    logic [7:0] byt;
    if (b < 8)       byt = model_buf[p][1];
    else if (b < 16) byt = model_buf[p][0];
    else             byt = model_buf[p][2];
    return byt[7 - (b % 8)];
  endfunction

  task automatic do_load(input int pix, input int col, input logic [7:0] lvl);
    bus.pixel_index = 3'(pix);
    bus.color_index = 2'(col);
    bus.color_level = lvl;
    bus.load_color  = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.load_color  = 1'b0;
    model_write(pix, col, lvl);
  endtask

  // Counts ready-low clocks after a reset edge; called at the negedge after it.
  task automatic check_reset_gap(input string tag);
    int  low    = 1;
    int  neo_hi = 0;
    bit  seen   = 0;
    reset = 1'b0;
    for (int i = 0; i < TL + 500; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (bus.ready_to_load === 1'b1 && bus.ready_to_send === 1'b1) begin
        seen = 1;
        break;
      end
      neo_hi += int'(neo_data);
      low++;
    end
    vectors++;
    if (!seen || low != TL) begin
      miscompares++;
      $display("[TB] FAIL %s ready_gap: low for %0d clocks (seen=%0d), expected %0d", tag, low, seen, TL);
    end
    vectors++;
    if (neo_hi != 0) begin
      miscompares++;
      $display("[TB] FAIL %s gap_neo: %0d high clocks, expected 0", tag, neo_hi);
    end
  endtask

  // Sends one frame from IDLE, records it, then checks every bit and the latch gap.
  task automatic run_frame(input string tag, input bit co_load, input int cpix,
                           input int ccol, input logic [7:0] clvl, input int inject_at);
    vectors++;
    if (bus.ready_to_send !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL %s pre_send_ready: got %b expected 1", tag, bus.ready_to_send);
    end
    if (co_load) begin
      bus.pixel_index = 3'(cpix);
      bus.color_index = 2'(ccol);
      bus.color_level = clvl;
      bus.load_color  = 1'b1;
      model_write(cpix, ccol, clvl);
    end
    bus.send_it = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.send_it    = 1'b0;
    bus.load_color = 1'b0;
    vectors++;
    if (neo_data !== 1'b0 || bus.ready_to_load !== 1'b0 || bus.ready_to_send !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL %s accept_edge: neo=%b rl=%b rs=%b expected 0 0 0", tag,
               neo_data, bus.ready_to_load, bus.ready_to_send);
    end
    for (int j = 1; j <= FRAME_LEN; j++) begin
      @(posedge clock);
      @(negedge clock);
      neo_tr[j] = neo_data;
      rl_tr[j]  = bus.ready_to_load;
      rs_tr[j]  = bus.ready_to_send;
      if (j == inject_at) begin
        bus.pixel_index = 3'd0;
        bus.color_index = 2'd0;
        bus.color_level = 8'h00;
        bus.load_color  = 1'b1;
        bus.send_it     = 1'b1;
      end else if (j == inject_at + 1) begin
        bus.load_color  = 1'b0;
        bus.send_it     = 1'b0;
      end
    end
    for (int b = 0; b < NBITS; b++) begin
      int start = 1 + b * TBIT;
      int run   = 0;
      int total = 0;
      int want  = exp_bit(b) ? T1 : T0;
      bit inrun = 1;
      for (int k = 0; k < TBIT; k++) begin
        total += int'(neo_tr[start + k]);
        if (inrun && neo_tr[start + k]) run++;
        else inrun = 0;
      end
      meas_bits[b] = (run == T1);
      vectors++;
      if (run != want || total != want) begin
        miscompares++;
        $display("[TB] FAIL %s bit%0d: high run %0d, high total %0d, expected %0d", tag, b, run, total, want);
      end
    end
    begin
      int ones   = 0;
      int rdy_hi = 0;
      for (int j = BITS_END + 1; j <= FRAME_LEN; j++) ones += int'(neo_tr[j]);
      for (int j = 1; j < FRAME_LEN; j++) rdy_hi += int'(rl_tr[j] | rs_tr[j]);
      vectors++;
      if (ones != 0) begin
        miscompares++;
        $display("[TB] FAIL %s latch_low: %0d high clocks after the bits, expected 0", tag, ones);
      end
      vectors++;
      if (rdy_hi != 0) begin
        miscompares++;
        $display("[TB] FAIL %s busy_ready: ready high on %0d clocks, expected 0", tag, rdy_hi);
      end
      vectors++;
      if (rl_tr[FRAME_LEN] != 1'b1 || rs_tr[FRAME_LEN] != 1'b1) begin
        miscompares++;
        $display("[TB] FAIL %s ready_return: rl=%b rs=%b expected 1 1", tag, rl_tr[FRAME_LEN], rs_tr[FRAME_LEN]);
      end
    end
  endtask

  function automatic logic [7:0] meas_byte(input int first);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[7 - i] = meas_bits[first + i];
    return v;
  endfunction

  function automatic int meas_ones();
    int n = 0;
    for (int b = 0; b < NBITS; b++) n += int'(meas_bits[b]);
    return n;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    vectors++;
    if (neo_data !== 1'b0 || bus.ready_to_load !== 1'b0 || bus.ready_to_send !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: neo=%b rl=%b rs=%b expected 0 0 0", neo_data,
               bus.ready_to_load, bus.ready_to_send);
    end
    model_clear();
    check_reset_gap("reset");
    run_frame("zero_frame", 0, 0, 0, 8'h00, -1);
    vectors++;
    if (meas_ones() != 0) begin
      miscompares++;
      $display("[TB] FAIL zero_frame ones: got %0d one-bits expected 0", meas_ones());
    end
  endtask

  task automatic test_load_and_send();
    do_load(0, 0, 8'hFF);
    do_load(1, 2, 8'hA5);
    run_frame("load_send", 0, 0, 0, 8'h00, -1);
    vectors++;
    if (meas_byte(0) !== 8'h00 || meas_byte(8) !== 8'hFF || meas_byte(40) !== 8'hA5) begin
      miscompares++;
      $display("[TB] FAIL load_send bytes: g0=%h r0=%h b1=%h expected 00 ff a5",
               meas_byte(0), meas_byte(8), meas_byte(40));
    end
  endtask

  task automatic test_ignored_during_frame();
    run_frame("busy_pulses", 0, 0, 0, 8'h00, 500);
    vectors++;
    if (meas_byte(8) !== 8'hFF) begin
      miscompares++;
      $display("[TB] FAIL busy_pulses red0: got %h expected ff", meas_byte(8));
    end
    prev_bits = meas_bits;
  endtask

  task automatic test_invalid_loads();
    do_load(5, 0, 8'h3C);
    do_load(7, 1, 8'hC3);
    do_load(2, 3, 8'h77);
    run_frame("invalid_loads", 0, 0, 0, 8'h00, -1);
    vectors++;
    if (meas_bits != prev_bits || meas_byte(8) !== 8'hFF) begin
      miscompares++;
      $display("[TB] FAIL invalid_loads frame_changed: red0=%h expected ff and identical frame", meas_byte(8));
    end
  endtask

  task automatic test_mid_frame_reset();
    int stop_at = 1 + 30 * TBIT + 4;
    bus.send_it = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.send_it = 1'b0;
    for (int j = 1; j <= stop_at; j++) begin
      @(posedge clock);
      @(negedge clock);
    end
    vectors++;
    if (neo_data !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL mid_reset bit30_high: got %b expected 1", neo_data);
    end
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    vectors++;
    if (neo_data !== 1'b0 || bus.ready_to_send !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mid_reset abort: neo=%b rs=%b expected 0 0", neo_data, bus.ready_to_send);
    end
    model_clear();
    check_reset_gap("mid_reset");
    run_frame("post_reset", 0, 0, 0, 8'h00, -1);
    vectors++;
    if (meas_ones() != 0) begin
      miscompares++;
      $display("[TB] FAIL post_reset ones: got %0d one-bits expected 0", meas_ones());
    end
  endtask

  task automatic test_load_with_send();
    run_frame("same_edge", 1, 4, 1, 8'h80, -1);
    vectors++;
    if (meas_bits[96] !== 1'b1 || meas_ones() != 1) begin
      miscompares++;
      $display("[TB] FAIL same_edge bit96: got %b with %0d one-bits, expected 1 with 1", meas_bits[96], meas_ones());
    end
  endtask

  task automatic test_random_frame();
    for (int n = 0; n < 12; n++) begin
      do_load(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 8'($urandom));
    end
    run_frame("random", 0, 0, 0, 8'h00, -1);
  endtask

  initial begin
    vectors         = 0;
    miscompares     = 0;
    reset           = 1'b1;
    bus.pixel_index = 3'd0;
    bus.color_index = 2'd0;
    bus.color_level = 8'h00;
    bus.load_color  = 1'b0;
    bus.send_it     = 1'b0;
    test_reset();
    test_load_and_send();
    test_ignored_during_frame();
    test_invalid_loads();
    test_mid_frame_reset();
    test_load_with_send();
    test_random_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/neopixel_frame_tx.md
Name: neopixel_frame_tx

Overview:
- Downstream stage of the pattern generator; it drives the LED strip.
- Accepts per-channel color writes over the load handshake into a 3-color frame buffer.
- On a send request, serializes the buffer onto the single-wire `neo_data` line using WS2812 bit timing, then holds the reset/latch gap.
- Exposes `ready_to_load` / `ready_to_send` so the generator knows when it may write or fire.

Parameters:
- NUM_PIXELS, 5, pixels on the strip; valid pixel_index range is 0..NUM_PIXELS-1.
- T_BIT, 63, clocks per bit period (1.25 us at 50 MHz).
- T0H, 18, clocks `neo_data` is high for a 0 bit.
- T1H, 35, clocks `neo_data` is high for a 1 bit.
- T_LATCH, 2500, clocks `neo_data` is held low after a frame (50 us).

Ports:
- clock, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- pixel_index, input, 3, pixel addressed by a load.
- color_index, input, 2, channel addressed by a load: 0=red, 1=green, 2=blue, 3=no-op.
- color_level, input, 8, intensity written on a load.
- load_color, input, 1, write strobe; honoured only while ready_to_load=1.
- send_it, input, 1, frame-send strobe; honoured only while ready_to_send=1.
- neo_data, output, 1, registered serial strip data.
- ready_to_load, output, 1, buffer writable this cycle.
- ready_to_send, output, 1, send accepted this cycle.

Behaviour:
- Clock and reset: one clock domain; reset is synchronous and active-high.
- Reset values: neo_data=0, ready_to_load=0, ready_to_send=0, all buffer bytes=0x00, all counters=0, state=LATCH.
  - Reset mid-frame aborts the frame: neo_data=0 from the next edge, and the full T_LATCH gap runs before ready reasserts.
- Storage: NUM_PIXELS x 3 bytes.
- Write rule: a write occurs on the edge where load_color=1 and ready_to_load=1, at buffer[pixel_index][color_index].
  - The write is ignored if pixel_index >= NUM_PIXELS or color_index == 3.
- States:
  - IDLE: ready_to_load=1, ready_to_send=1, neo_data=0.
    - send_it=1 goes to BIT_HIGH.
    - Otherwise stay in IDLE.
  - BIT_HIGH: neo_data=1 for Txh clocks (T1H if the current bit is 1, else T0H), then go to BIT_LOW.
  - BIT_LOW: neo_data=0 for T_BIT-Txh clocks.
    - Then advance the bit pointer and go to BIT_HIGH.
    - After the last bit of the last pixel, go to LATCH.
  - LATCH: neo_data=0 for T_LATCH clocks, then go to IDLE.
  - Both ready outputs are 0 in BIT_HIGH, BIT_LOW and LATCH.
- Send latency: send_it is sampled at edge k. neo_data first reads 1 after edge k+1 and the first bit occupies exactly T_BIT clocks.
- Bit order:
  - Pixels are sent in order 0..NUM_PIXELS-1.
  - Within each pixel, send green[7:0], then red[7:0], then blue[7:0], MSB first, for 24 bits per pixel.
- Frame length: exactly NUM_PIXELS*24*T_BIT clocks of bits, then T_LATCH low clocks.
  - Default: 7560 + 2500 clocks from the first high to ready reassertion.
- Simultaneous load_color and send_it in IDLE:
  - The write commits on the same edge.
  - The frame transmits the newly written value.
- Loads during a send: load_color while ready_to_load=0 is ignored, and the buffer stays frozen for the whole frame.
- send_it outside IDLE is ignored; it is not queued.
- The buffer persists across frames; only reset clears it.
- Counters:
  - Cycle counter is clog2(T_LATCH+1) bits wide and reused by every state.
  - Bit counter runs 0..23.
  - Pixel counter runs 0..NUM_PIXELS-1; it wraps to 0 on entering LATCH.
- neo_data comes straight from a flop; it has no combinational path from the inputs.

Test Plan:
1. Reset, then hold idle for 2500 clocks:
   - neo_data=0 throughout.
   - ready_to_load=0 and ready_to_send=0 for 2500 clocks, then both become 1.
   - A send with an all-zero buffer yields 120 bits, each 18 clocks high and 45 clocks low.
2. Load pixel0 red=0xFF, pixel1 blue=0xA5, then send:
   - Bits 0-7 are 0 (18 clocks high).
   - Bits 8-15 are 1 (35 clocks high).
   - Bits 40-47 read 10100101.
   - Total of 7560 clocks before entering LATCH.
3. Assert load_color and send_it on the same edge with pixel4 green=0x80:
   - Bit 96 is 1.
   - All other bits are 0.
4. During a frame, pulse load_color with pixel0 red=0x00 and pulse send_it:
   - Both are ignored and the frame is unchanged.
   - The next frame still shows red=0xFF.
5. In IDLE, load with pixel_index=5, pixel_index=7, and color_index=3:
   - The buffer is unchanged and the next frame is identical to the previous one.
6. Assert reset at bit 30 of a frame:
   - neo_data=0 at the next edge.
   - Ready stays low for 2500 clocks.
   - The next frame is all zeros.
